ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xFF (reset), over the same ps2_clk/ps2_data pair used by the keyboard receiver. It generates the request-to-send sequence, shifts the data out LSB first with odd parity, checks the device acknowledge, and reports done or error. Its busy output gates the keyboard receiver so the receiver ignores the frame while this block is transmitting.

---
 rtl/ps2_host_tx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, LSB-first data with odd parity,
// device acknowledge check, and a watchdog on the device clock.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_CYCLES   = 100,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             clk_low_q, clk_low_d;
  logic             data_low_q, data_low_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             timeout_err_q, timeout_err_d;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;
  logic wd_expired;

  // Synchronizers reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall       = clk_prev & ~clk_sync;
  assign wd_expired = (wdog_q == WD_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      wdog_q        <= '0;
      bit_cnt_q     <= '0;
      clk_low_q     <= 1'b0;
      data_low_q    <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      wdog_q        <= wdog_d;
      bit_cnt_q     <= bit_cnt_d;
      clk_low_q     <= clk_low_d;
      data_low_q    <= data_low_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    wdog_d        = wdog_q;
    bit_cnt_d     = bit_cnt_q;
    clk_low_d     = clk_low_q;
    data_low_d    = data_low_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          cnt_d     = '0;
          clk_low_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d      = '0;
          data_low_d = 1'b1;
          state_d    = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d     = '0;
          clk_low_d = 1'b0;
          bit_cnt_d = '0;
          wdog_d    = '0;
          state_d   = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND, ACK, RELEASE: begin
        wdog_d = wdog_q + 1'b1;
        if (state_q == SEND && fall) begin
          wdog_d     = '0;
          data_low_d = ~shift_q[0];
          shift_d    = {1'b0, shift_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = ACK;
        end else if (state_q == ACK && fall) begin
          wdog_d = '0;
          if (!data_sync) begin
            state_d = RELEASE;
          end else begin
            ack_err_d  = 1'b1;
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (state_q == RELEASE && clk_sync && data_sync) begin
          wdog_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wd_expired) begin
          // Device stopped clocking: give the bus back and abandon the frame.
          wdog_d        = '0;
          timeout_err_d = 1'b1;
          clk_low_d     = 1'b0;
          data_low_d    = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready           = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign ack_err            = ack_err_q;
  assign timeout_err        = timeout_err_q;
  assign ps2_clk_drive_low  = clk_low_q;
  assign ps2_data_drive_low = data_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND PS/2 bus and a simple device model.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int STR  = 10;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk;
  logic       clrn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, ack_err, timeout_err;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       dev_clk, dev_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ack_cnt  = 0;
  int to_cnt   = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES  (STR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .clrn              (clrn),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .done              (done),
    .ack_err           (ack_err),
    .timeout_err       (timeout_err),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_data_in       (ps2_data_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low)
  );

  assign ps2_clk_in  = dev_clk & ~ps2_clk_drive_low;
  assign ps2_data_in = dev_data & ~ps2_data_drive_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status pulse counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (done)        done_cnt++;
    if (ack_err)     ack_cnt++;
    if (timeout_err) to_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 5000) begin
      if (busy && !ps2_clk_drive_low && ps2_data_drive_low) ok = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
  endtask

  // Device model: clocks n_edges falling edges, samples data at each rising edge.
  task automatic device_frame(input int n_edges, input bit do_ack,
                              output logic [9:0] bits, output bit ok);
    bits = '0;
    wait_release(ok);
    if (ok) begin
      for (int e = 1; e <= n_edges; e++) begin
        if (e == 11 && do_ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (e <= 10) bits[e-1] = ps2_data_in;
      end
      if (n_edges == 11) begin
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
      end
    end
  endtask

  initial begin
    logic [9:0] bits;
    bit         ok;
    int         n;
    int         d0, a0, t0;

    clrn     = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #2 clrn  = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_tx_ready", tx_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_clk_low", ps2_clk_drive_low, 0);
    check_output("rst_data_low", ps2_data_drive_low, 0);
    check_output("rst_pulses", {done, ack_err, timeout_err}, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 0xED with acknowledge; check inhibit and start durations.
    $display("[TB] send 0xED");
    apply_stimulus(8'hED);
    n = 0;
    while (ps2_clk_drive_low && !ps2_data_drive_low && n < 1000) begin n++; @(negedge clk); end
    check_output("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_drive_low && ps2_data_drive_low && n < 1000) begin n++; @(negedge clk); end
    check_output("start_len", n, STR);
    device_frame(11, 1'b1, bits, ok);
    check_output("ed_started", ok, 1);
    check_output("ed_bits", bits, 10'h3ED);
    repeat (10) @(negedge clk);
    check_output("ed_done_cnt", done_cnt, 1);
    check_output("ed_tx_ready", tx_ready, 1);

    // Back-to-back 0x00 then 0x01 with tx_valid held.
    $display("[TB] send 0x00 then 0x01");
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data  = 8'h01;
    check_output("b2b_busy", busy, 1);
    device_frame(11, 1'b1, bits, ok);
    check_output("b00_bits", bits, 10'h300);
    n = 0;
    while (!done && n < 200) begin n++; @(negedge clk); end
    check_output("b00_done_seen", done, 1);
    check_output("b00_ready_at_done", tx_ready, 1);
    @(negedge clk);
    check_output("b01_accepted", busy, 1);
    check_output("b00_done_cnt", done_cnt, 2);
    tx_valid = 1'b0;
    device_frame(11, 1'b1, bits, ok);
    check_output("b01_bits", bits, 10'h201);
    repeat (10) @(negedge clk);
    check_output("b01_done_cnt", done_cnt, 3);

    // Missing acknowledge.
    $display("[TB] send 0xAB without ack");
    d0 = done_cnt; a0 = ack_cnt;
    apply_stimulus(8'hAB);
    device_frame(11, 1'b0, bits, ok);
    repeat (10) @(negedge clk);
    check_output("nak_ack_err", ack_cnt - a0, 1);
    check_output("nak_no_done", done_cnt - d0, 0);
    check_output("nak_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    check_output("nak_idle", tx_ready, 1);

    // Device never clocks.
    $display("[TB] watchdog");
    t0 = to_cnt;
    apply_stimulus(8'h12);
    wait_release(ok);
    check_output("to_released", ok, 1);
    n = 0;
    while (!timeout_err && n < 3000) begin n++; @(negedge clk); end
    check_output("to_len", n, TO);
    check_output("to_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    check_output("to_idle", busy, 0);
    @(negedge clk);
    check_output("to_cnt", to_cnt - t0, 1);

    // tx_valid during SEND must be ignored.
    $display("[TB] send 0xFF with stray request");
    d0 = done_cnt;
    apply_stimulus(8'hFF);
    fork
      device_frame(11, 1'b1, bits, ok);
      begin
        repeat (INH + STR + 80) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check_output("ff_bits", bits, 10'h3FF);
    repeat (10) @(negedge clk);
    check_output("ff_done_cnt", done_cnt - d0, 1);
    repeat (20) @(negedge clk);
    check_output("ff_no_requeue", busy, 0);

    // Reset mid-frame, then a clean 0xF4.
    $display("[TB] reset mid-frame");
    d0 = done_cnt; a0 = ack_cnt; t0 = to_cnt;
    apply_stimulus(8'h3C);
    device_frame(4, 1'b1, bits, ok);
    #3 clrn = 1'b0;
    #1;
    check_output("rst_mid_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    check_output("rst_mid_busy", busy, 0);
    repeat (5) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);
    check_output("rst_mid_no_pulse", {done_cnt - d0, ack_cnt - a0, to_cnt - t0}, 0);
    apply_stimulus(8'hF4);
    device_frame(11, 1'b1, bits, ok);
    check_output("f4_bits", bits, 10'h2F4);
    repeat (10) @(negedge clk);
    check_output("f4_done_cnt", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
